// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, ALU pipeline latency and the op
// driven onto the ALU when nothing is issued.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    AND      = 4'd1,
    SLL      = 4'd2,
    SRL      = 4'd3,
    OR       = 4'd4,
    XOR      = 4'd5,
    OUT_ONE  = 4'd6,
    OUT_ZERO = 4'd7,
    BRANCH   = 4'd8,
    SRA      = 4'd9,
    LUI      = 4'd10,
    SUB      = 4'd11,
    AUIPC    = 4'd12
  } alu_op_t;

  localparam int      ALU_LATENCY = 1;
  localparam alu_op_t ALU_IDLE_OP = OUT_ZERO;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the arbiter's requester, ALU and response signals.
// The slave modport is the arbiter's view; master is everything around it.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*4-1:0]  req_op_i;
  logic [NUM_REQ*32-1:0] req_a_i;
  logic [NUM_REQ*32-1:0] req_b_i;

  logic [3:0]            alu_op_o;
  logic [31:0]           alu_a_o;
  logic [31:0]           alu_b_o;
  logic [31:0]           alu_result_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [31:0]           rsp_data_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    output req_ready_o, alu_op_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_op_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

endinterface

// File: rtl/alu_arbiter_rsp_fifo.sv
// Small synchronous response FIFO holding {requester id, result} words.
// rdata shows the head entry; it is only meaningful while empty is low.
module alu_arb_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter int  W     = 33,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since count gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters. Picks one request per
// cycle, drives the ALU, remembers who owns the in-flight op and queues the
// result in a response FIFO. Issue is throttled so the FIFO can never overflow.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int RSP_DEPTH = 2,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]    grant;
  logic               found;
  logic               can_issue;
  logic               issue;
  logic               pop;
  logic               rsp_valid;
  logic [31:0]        occupancy;
  logic               in_flight;
  logic [ID_W-1:0]    inflight_id;
  logic [ID_W+31:0]   fifo_rdata;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Slots claimed after this cycle's pop: the op in the ALU plus buffered results.
  assign occupancy = 32'(in_flight) + 32'(fifo_count) - 32'(pop);
  assign can_issue = (occupancy < 32'(RSP_DEPTH));
  assign issue     = !rst && can_issue && found;

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Fixed priority scan: the lowest-numbered valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid_i[i]) begin
        found = 1'b1;
        grant = ID_W'(i);
      end
    end
  end

`else

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (scan_sum >= (ID_W + 1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W + 1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!found && bus.req_valid_i[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

`endif

  // Accept strobe and ALU operands come straight from the winner; idle op otherwise.
  always_comb begin
    bus.req_ready_o = '0;
    bus.alu_op_o    = ALU_IDLE_OP;
    bus.alu_a_o     = '0;
    bus.alu_b_o     = '0;
    if (issue) begin
      bus.req_ready_o[grant] = 1'b1;
      bus.alu_op_o           = bus.req_op_i[{grant, 2'b00} +: 4];
      bus.alu_a_o            = bus.req_a_i[{grant, 5'b00000} +: 32];
      bus.alu_b_o            = bus.req_b_i[{grant, 5'b00000} +: 32];
    end
  end

  // Remember whether the ALU holds one of our ops and who it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight   <= 1'b0;
      inflight_id <= '0;
    end else begin
      in_flight   <= issue;
      inflight_id <= grant;
    end
  end

  alu_arb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (ID_W + 32)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_flight),
    .pop   (pop),
    .wdata ({inflight_id, bus.alu_result_i}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid       = !rst && !fifo_empty;
  assign pop             = rsp_valid && bus.rsp_ready_i;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = rsp_valid ? fifo_rdata[ID_W+31 -: ID_W] : '0;
  assign bus.rsp_data_o  = rsp_valid ? fifo_rdata[31:0] : '0;

  // The issue throttle guarantees a returning result always has room.
  assert property (@(posedge clk) disable iff (rst) !(in_flight && fifo_full && !pop));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a behavioural
// registered ALU. Also pokes the response FIFO directly to cover
// push-and-pop while full. Expectations follow ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam logic [31:0] ALT_READY = 32'h1;
  localparam logic [31:0] ALT_ID    = 32'h0;
  localparam logic [31:0] ALT_DATA  = 32'h2;
`else
  localparam logic [31:0] ALT_READY = 32'h2;
  localparam logic [31:0] ALT_ID    = 32'h1;
  localparam logic [31:0] ALT_DATA  = 32'h4;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic        f_push;
  logic        f_pop;
  logic [32:0] f_wdata;
  logic [32:0] f_rdata;
  logic [1:0]  f_count;
  logic        f_full;
  logic        f_empty;

  alu_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus ();

  alu_arbiter #(.NUM_REQ(2), .RSP_DEPTH(2), .ID_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_arb_rsp_fifo #(.DEPTH(2), .W(33)) fifo_dut (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (f_wdata),
    .rdata (f_rdata),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: result of the ops driven this cycle appears next cycle.
  initial bus.alu_result_i = '0;
  always @(posedge clk) begin
    case (bus.alu_op_o)
      ADD:     bus.alu_result_i <= bus.alu_a_o + bus.alu_b_o;
      SUB:     bus.alu_result_i <= bus.alu_a_o - bus.alu_b_o;
      AND:     bus.alu_result_i <= bus.alu_a_o & bus.alu_b_o;
      OR:      bus.alu_result_i <= bus.alu_a_o | bus.alu_b_o;
      XOR:     bus.alu_result_i <= bus.alu_a_o ^ bus.alu_b_o;
      OUT_ONE: bus.alu_result_i <= 32'd1;
      default: bus.alu_result_i <= 32'd0;
    endcase
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rsp_ready);
    bus.req_valid_i = valid;
    bus.req_op_i    = {op1, op0};
    bus.req_a_i     = {a1, a0};
    bus.req_b_i     = {b1, b0};
    bus.rsp_ready_i = rsp_ready;
    #1;
  endtask

  task automatic idle(input logic rsp_ready);
    applyStimulus(2'b00, ADD, 32'd0, 32'd0, ADD, 32'd0, 32'd0, rsp_ready);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] valid, input logic [31:0] id,
                          input logic [31:0] data);
    checkOutput({tag, "_valid"}, 32'(bus.rsp_valid_o), valid);
    checkOutput({tag, "_id"}, 32'(bus.rsp_id_o), id);
    checkOutput({tag, "_data"}, bus.rsp_data_o, data);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    f_push      = 1'b0;
    f_pop       = 1'b0;
    f_wdata     = '0;

    // Reset with both requesters asserting valid: nothing may be accepted.
    rst = 1'b1;
    applyStimulus(2'b11, ADD, 32'd1, 32'd1, ADD, 32'd1, 32'd1, 1'b1);
    waitCycle();
    waitCycle();
    checkOutput("rst_ready", 32'(bus.req_ready_o), 32'h0);
    checkRsp("rst_rsp", 32'h0, 32'h0, 32'h0);
    checkOutput("rst_alu_op", 32'(bus.alu_op_o), 32'd7);
    checkOutput("rst_alu_a", bus.alu_a_o, 32'h0);
    checkOutput("rst_alu_b", bus.alu_b_o, 32'h0);
    checkOutput("rst_fifo_count", 32'(f_count), 32'h0);
    rst = 1'b0;
    idle(1'b1);
    waitCycle();

    // Response FIFO on its own: fill, push+pop at full, drain, pop when empty.
    $display("[TB] response FIFO direct checks");
    f_push  = 1'b1;
    f_wdata = 33'h0_0000_00AA;
    waitCycle();
    f_wdata = 33'h1_0000_00BB;
    waitCycle();
    checkOutput("fifo_full_count", 32'(f_count), 32'd2);
    checkOutput("fifo_full_flag", 32'(f_full), 32'd1);
    checkOutput("fifo_head_a", f_rdata[31:0], 32'hAA);
    f_pop   = 1'b1;
    f_wdata = 33'h0_0000_00CC;
    waitCycle();
    checkOutput("fifo_pushpop_count", 32'(f_count), 32'd2);
    checkOutput("fifo_head_b", f_rdata[31:0], 32'hBB);
    checkOutput("fifo_head_b_id", 32'(f_rdata[32]), 32'd1);
    f_push = 1'b0;
    waitCycle();
    checkOutput("fifo_drain_count", 32'(f_count), 32'd1);
    checkOutput("fifo_head_c", f_rdata[31:0], 32'hCC);
    waitCycle();
    checkOutput("fifo_empty_flag", 32'(f_empty), 32'd1);
    waitCycle();
    checkOutput("fifo_pop_empty_count", 32'(f_count), 32'd0);
    f_pop = 1'b0;

    // Single request from requester 0: ADD 5+7.
    $display("[TB] single requests");
    applyStimulus(2'b01, ADD, 32'd5, 32'd7, ADD, 32'd0, 32'd0, 1'b1);
    checkOutput("single0_ready", 32'(bus.req_ready_o), 32'h1);
    checkOutput("single0_alu_op", 32'(bus.alu_op_o), 32'd0);
    checkOutput("single0_alu_a", bus.alu_a_o, 32'd5);
    checkOutput("single0_alu_b", bus.alu_b_o, 32'd7);
    checkOutput("single0_rsp_t0", 32'(bus.rsp_valid_o), 32'd0);
    waitCycle();
    idle(1'b1);
    checkOutput("single0_rsp_t1", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("single0_idle_op", 32'(bus.alu_op_o), 32'd7);
    waitCycle();
    checkRsp("single0_rsp_t2", 32'd1, 32'd0, 32'd12);
    waitCycle();
    checkOutput("single0_rsp_t3", 32'(bus.rsp_valid_o), 32'd0);

    // Single request from requester 1: AND 0xFF & 0x0F.
    applyStimulus(2'b10, ADD, 32'd0, 32'd0, AND, 32'hFF, 32'h0F, 1'b1);
    checkOutput("single1_ready", 32'(bus.req_ready_o), 32'h2);
    checkOutput("single1_alu_op", 32'(bus.alu_op_o), 32'd1);
    checkOutput("single1_alu_a", bus.alu_a_o, 32'hFF);
    waitCycle();
    idle(1'b1);
    waitCycle();
    checkRsp("single1_rsp", 32'd1, 32'd1, 32'h0F);
    waitCycle();
    checkOutput("single1_rsp_done", 32'(bus.rsp_valid_o), 32'd0);

    // Contention: req0 SUB 10-3, req1 XOR F0^0F, both held valid.
    $display("[TB] contention");
    applyStimulus(2'b11, SUB, 32'd10, 32'd3, XOR, 32'hF0, 32'h0F, 1'b1);
    checkOutput("cont_c0_ready", 32'(bus.req_ready_o), 32'h1);
    checkOutput("cont_c0_alu_op", 32'(bus.alu_op_o), 32'd11);
    waitCycle();
    checkOutput("cont_c1_ready", 32'(bus.req_ready_o), ALT_READY);
    checkOutput("cont_c1_rsp", 32'(bus.rsp_valid_o), 32'd0);
    waitCycle();
    checkOutput("cont_c2_ready", 32'(bus.req_ready_o), 32'h1);
    checkRsp("cont_c2_rsp", 32'd1, 32'd0, 32'd7);
    waitCycle();
    checkOutput("cont_c3_ready", 32'(bus.req_ready_o), ALT_READY);
    checkRsp("cont_c3_rsp", 32'd1, ALT_ID, (ALT_ID == 32'd1) ? 32'hFF : 32'd7);
    waitCycle();
    idle(1'b1);
    checkRsp("cont_c4_rsp", 32'd1, 32'd0, 32'd7);
    waitCycle();
    checkRsp("cont_c5_rsp", 32'd1, ALT_ID, (ALT_ID == 32'd1) ? 32'hFF : 32'd7);
    waitCycle();
    checkOutput("cont_c6_rsp", 32'(bus.rsp_valid_o), 32'd0);

    // Backpressure: consumer stalled, only two ops may be outstanding.
    $display("[TB] backpressure");
    applyStimulus(2'b01, ADD, 32'd1, 32'd2, ADD, 32'd0, 32'd0, 1'b0);
    checkOutput("bp_b0_ready", 32'(bus.req_ready_o), 32'h1);
    waitCycle();
    applyStimulus(2'b01, ADD, 32'd3, 32'd4, ADD, 32'd0, 32'd0, 1'b0);
    checkOutput("bp_b1_ready", 32'(bus.req_ready_o), 32'h1);
    waitCycle();
    applyStimulus(2'b01, ADD, 32'd5, 32'd6, ADD, 32'd0, 32'd0, 1'b0);
    checkOutput("bp_b2_ready", 32'(bus.req_ready_o), 32'h0);
    checkOutput("bp_b2_alu_op", 32'(bus.alu_op_o), 32'd7);
    checkRsp("bp_b2_rsp", 32'd1, 32'd0, 32'd3);
    waitCycle();
    checkOutput("bp_b3_ready", 32'(bus.req_ready_o), 32'h0);
    checkRsp("bp_b3_rsp", 32'd1, 32'd0, 32'd3);
    waitCycle();
    checkOutput("bp_b4_ready_stalled", 32'(bus.req_ready_o), 32'h0);
    applyStimulus(2'b01, ADD, 32'd5, 32'd6, ADD, 32'd0, 32'd0, 1'b1);
    checkOutput("bp_b4_ready_resume", 32'(bus.req_ready_o), 32'h1);
    checkRsp("bp_b4_rsp", 32'd1, 32'd0, 32'd3);
    waitCycle();
    idle(1'b1);
    checkRsp("bp_b5_rsp", 32'd1, 32'd0, 32'd7);
    waitCycle();
    checkRsp("bp_b6_rsp", 32'd1, 32'd0, 32'd11);
    waitCycle();
    checkOutput("bp_b7_rsp", 32'(bus.rsp_valid_o), 32'd0);

    // Reset the cycle after an issue: the in-flight result must vanish.
    $display("[TB] reset mid-operation");
    applyStimulus(2'b01, ADD, 32'd2, 32'd2, ADD, 32'd0, 32'd0, 1'b1);
    checkOutput("rmo_issue_ready", 32'(bus.req_ready_o), 32'h1);
    waitCycle();
    rst = 1'b1;
    idle(1'b1);
    checkOutput("rmo_r1_rsp", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("rmo_r1_alu_op", 32'(bus.alu_op_o), 32'd7);
    waitCycle();
    rst = 1'b0;
    idle(1'b1);
    checkOutput("rmo_r2_rsp", 32'(bus.rsp_valid_o), 32'd0);
    waitCycle();
    checkOutput("rmo_r3_rsp", 32'(bus.rsp_valid_o), 32'd0);
    waitCycle();
    checkOutput("rmo_r4_rsp", 32'(bus.rsp_valid_o), 32'd0);

    // Undefined op code 13 from requester 1 passes through; ALU returns 0.
    applyStimulus(2'b10, ADD, 32'd0, 32'd0, 4'd13, 32'd9, 32'd9, 1'b1);
    checkOutput("op13_ready", 32'(bus.req_ready_o), 32'h2);
    checkOutput("op13_alu_op", 32'(bus.alu_op_o), 32'd13);
    waitCycle();
    idle(1'b1);
    waitCycle();
    checkRsp("op13_rsp", 32'd1, 32'd1, 32'd0);
    waitCycle();
    checkOutput("op13_rsp_done", 32'(bus.rsp_valid_o), 32'd0);

    // Arbitration policy: req0 ADD 1+1, req1 ADD 2+2, both held valid.
    $display("[TB] arbitration policy");
    applyStimulus(2'b11, ADD, 32'd1, 32'd1, ADD, 32'd2, 32'd2, 1'b1);
    checkOutput("prio_p0_ready", 32'(bus.req_ready_o), 32'h1);
    waitCycle();
    checkOutput("prio_p1_ready", 32'(bus.req_ready_o), ALT_READY);
    waitCycle();
    checkOutput("prio_p2_ready", 32'(bus.req_ready_o), 32'h1);
    checkRsp("prio_p2_rsp", 32'd1, 32'd0, 32'd2);
    waitCycle();
    checkOutput("prio_p3_ready", 32'(bus.req_ready_o), ALT_READY);
    checkRsp("prio_p3_rsp", 32'd1, ALT_ID, ALT_DATA);
    waitCycle();
    idle(1'b1);
    waitCycle();
    waitCycle();
    checkOutput("prio_drained", 32'(bus.rsp_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU between NUM_REQ requesters, e.g. the execute stage and the branch/AUIPC address path.
- Accepts operations with a valid/ready handshake and picks one per cycle by round-robin.
- Drives the ALU operand inputs, tracks each in-flight operation's requester ID, and returns the result through a small response FIFO with backpressure.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- RSP_DEPTH, 2, response FIFO depth; minimum 2 for full throughput.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester operation valid
- req_ready_o  out  NUM_REQ  per-requester accept
- req_op_i  in  NUM_REQ*4  packed alu_op_t per requester
- req_a_i  in  NUM_REQ*32  packed operand A
- req_b_i  in  NUM_REQ*32  packed operand B
- alu_op_o  out  4  to ALU op input
- alu_a_o  out  32  to ALU operand A
- alu_b_o  out  32  to ALU operand B
- alu_result_i  in  32  registered ALU result; valid the cycle after issue
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  consumer accepts response
- rsp_id_o  out  ID_W  requester that owns the response
- rsp_data_o  out  32  result

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - Clears the RR pointer to 0, in_flight to 0 and the FIFO.
  - Reset outputs: req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, alu_op_o=OUT_ZERO (7), alu_a_o=0, alu_b_o=0.
  - Reset mid-operation discards in-flight and buffered results; the result arriving the cycle after reset release is ignored.
- Issue condition: can_issue = (in_flight + fifo_count - pop) < RSP_DEPTH, where pop = rsp_valid_o & rsp_ready_i.
- Grant (combinational): when can_issue, grant the first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  - req_ready_o is one-hot on the grant, otherwise all zero.
  - A request is accepted only when valid & ready.
  - Requesters must hold op/a/b stable while valid and not ready.
- ALU drive (combinational): on issue, alu_op_o/alu_a_o/alu_b_o are the granted requester's fields. With no issue they are OUT_ZERO/0/0. Op codes 13..15 pass through unchanged; the ALU returns 0 for them.
- Pointer update: on issue, rr_ptr <= grant+1 mod NUM_REQ; with no issue, rr_ptr holds.
- Tracking: in_flight <= issue; inflight_id <= grant.
- Latency:
  - Issue at cycle T; alu_result_i is valid in T+1.
  - When in_flight is set in T+1, push {inflight_id, alu_result_i} at the end of T+1.
  - rsp_valid_o is high from T+2. Minimum latency is 2 cycles.
- FIFO:
  - Push and pop in the same cycle is legal when full; count is unchanged.
  - Push into a full FIFO is unreachable by construction; assert it never happens.
  - Pop when empty does nothing.
  - Pointers wrap modulo RSP_DEPTH.
  - Responses leave in issue order.
- Throughput: 1 op/cycle sustained with rsp_ready_i held high. With rsp_ready_i low, at most RSP_DEPTH operations are outstanding; further issue stalls.
- No starvation: a requester held valid is granted within NUM_REQ issuing cycles.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented, so requester 0 can starve the others.
- Undefined: round-robin as above.

Decomposition:
- alu_pkg holds:
  - alu_op_t enum with encodings ADD=0, AND=1, SLL=2, SRL=3, OR=4, XOR=5, OUT_ONE=6, OUT_ZERO=7, BRANCH=8, SRA=9, LUI=10, SUB=11, AUIPC=12.
  - ALU_LATENCY=1.
  - ALU_IDLE_OP=OUT_ZERO.
- Sub-module alu_arb_rsp_fifo: parameterised sync FIFO over {ID_W, 32}, exposing count/full/empty.

Test Plan:
- Single request: req0 valid, op ADD, a=5, b=7 -> ready0 high at T; alu_* driven 0/5/7 at T; rsp_valid at T+2 with id=0, data=12.
- Contention: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; four responses are back-to-back with ids 0,1,0,1. Operations are req0 SUB 10-3 and req1 XOR 0xF0^0x0F, giving data 7, 0xFF, 7, 0xFF.
- Backpressure: rsp_ready=0 with req0 always valid -> exactly 2 issues, then ready0 stays 0. Raise rsp_ready -> responses drain in order and issue resumes.
- Same-cycle push/pop at full: FIFO full, rsp_ready=1, in-flight result arriving -> count stays 2 and no data is lost or duplicated.
- Reset mid-operation: assert rst the cycle after issue -> rsp_valid=0 the next cycle; no stale response appears after release; alu_op_o=7.
- ALU_ARB_FIXED_PRIO_EN defined, both valid continuously -> only id 0 is granted. Undefined -> alternating grants.
